// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: one-hot FSM encodings,
// parity-mode constants and the bit-vote helper.
package uart_pkg;

  localparam int unsigned NB_STATE = 6;

  typedef enum logic [NB_STATE-1:0] {
    ST_IDLE   = 6'b000001,
    ST_START  = 6'b000010,
    ST_DATA   = 6'b000100,
    ST_PARITY = 6'b001000,
    ST_STOP   = 6'b010000,
    ST_DONE   = 6'b100000
  } state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // 2-of-3 vote over the three late samples of a bit
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line; resets to the idle (high) level.
module uart_rx_sync (
  input  logic i_clock,
  input  logic i_reset,
  input  logic rx_async,
  output logic rx_sync
);

  logic meta;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      meta    <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      meta    <= rx_async;
      rx_sync <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver with a one-entry output register and overrun flag.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned NB_DATA    = 8,
  parameter int unsigned N_TICKS    = 16,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_rx,
  input  logic               i_signal_tick,
  input  logic               i_ready,
  output logic               o_valid,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_frame_err,
  output logic               o_parity_err,
  output logic               o_overrun
);

  localparam int unsigned NB_CNT = $clog2(N_TICKS);
  localparam int unsigned NB_IDX = $clog2(NB_DATA);

  localparam logic [NB_CNT-1:0] CNT_HALF = NB_CNT'(N_TICKS / 2 - 1);
  localparam logic [NB_CNT-1:0] CNT_S0   = NB_CNT'(N_TICKS - 3);
  localparam logic [NB_CNT-1:0] CNT_S1   = NB_CNT'(N_TICKS - 2);
  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(N_TICKS - 1);
  localparam logic [NB_IDX-1:0] IDX_LAST = NB_IDX'(NB_DATA - 1);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

  generate
    if (NB_DATA < 5 || NB_DATA > 9 || N_TICKS < 8 || (N_TICKS % 2) != 0 ||
        STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_bad_params
      $error("uart_rx_core: illegal parameter combination");
    end
  endgenerate

  state_e              state;
  state_e              state_next;
  logic                rx_sync;
  logic [NB_CNT-1:0]   cnt;
  logic [NB_IDX-1:0]   idx;
  logic                stop_idx;
  logic [NB_DATA-1:0]  shreg;
  logic                s0;
  logic                s1;
  logic                ferr_acc;
  logic                bit_last;
  logic                bit_tick;
  logic                maj;

  logic cnt_clr_c;
  logic cnt_inc_c;
  logic idx_clr_c;
  logic sample_c;
  logic shift_c;
  logic stop_cap_c;
  logic load_c;
  logic overrun_c;

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_MODE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;
  logic parity_bit;
  logic par_cap_c;
`endif

  uart_rx_sync u_sync (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .rx_async(i_rx),
    .rx_sync (rx_sync)
  );

  assign bit_last = (cnt == CNT_LAST);
  assign bit_tick = i_signal_tick && bit_last;
  assign maj      = majority3(s0, s1, rx_sync);

  always_ff @(posedge i_clock) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (!rx_sync) state_next = ST_START;
      ST_START: if (i_signal_tick && cnt == CNT_HALF) state_next = rx_sync ? ST_IDLE : ST_DATA;
      ST_DATA: begin
        if (bit_tick && idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
          state_next = ST_PARITY;
`else
          state_next = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: if (bit_tick) state_next = ST_STOP;
`endif
      ST_STOP:  if (bit_tick && stop_idx == STOP_LAST) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Per-state datapath controls; counter wraps at the decision tick of each bit
  always_comb begin
    cnt_clr_c  = 1'b0;
    cnt_inc_c  = 1'b0;
    idx_clr_c  = 1'b0;
    sample_c   = 1'b0;
    shift_c    = 1'b0;
    stop_cap_c = 1'b0;
    load_c     = 1'b0;
    overrun_c  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_cap_c  = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        cnt_clr_c = 1'b1;
        idx_clr_c = 1'b1;
      end
      ST_START: begin
        idx_clr_c = 1'b1;
        if (i_signal_tick) begin
          if (cnt == CNT_HALF) cnt_clr_c = 1'b1;
          else                 cnt_inc_c = 1'b1;
        end
      end
      ST_DATA: begin
        sample_c  = i_signal_tick;
        cnt_inc_c = i_signal_tick && !bit_last;
        cnt_clr_c = bit_tick;
        shift_c   = bit_tick;
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        sample_c  = i_signal_tick;
        cnt_inc_c = i_signal_tick && !bit_last;
        cnt_clr_c = bit_tick;
        par_cap_c = bit_tick;
      end
`endif
      ST_STOP: begin
        sample_c   = i_signal_tick;
        cnt_inc_c  = i_signal_tick && !bit_last;
        cnt_clr_c  = bit_tick;
        stop_cap_c = bit_tick;
      end
      ST_DONE: begin
        load_c    = !o_valid || i_ready;
        overrun_c = o_valid && !i_ready;
      end
      default: begin
        cnt_clr_c = 1'b1;
        idx_clr_c = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cnt      <= '0;
      idx      <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      s0       <= 1'b0;
      s1       <= 1'b0;
      ferr_acc <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      if (cnt_clr_c)      cnt <= '0;
      else if (cnt_inc_c) cnt <= cnt + NB_CNT'(1);

      if (idx_clr_c) begin
        idx      <= '0;
        stop_idx <= 1'b0;
        ferr_acc <= 1'b0;
      end else begin
        if (shift_c)    idx      <= idx + NB_IDX'(1);
        if (stop_cap_c) stop_idx <= stop_idx + 1'b1;
        if (stop_cap_c && !maj) ferr_acc <= 1'b1;
      end

      if (sample_c && cnt == CNT_S0) s0 <= rx_sync;
      if (sample_c && cnt == CNT_S1) s1 <= rx_sync;
      if (shift_c) shreg <= {maj, shreg[NB_DATA-1:1]};
`ifdef UART_RX_PARITY_EN
      if (par_cap_c) parity_bit <= maj;
`endif
    end
  end

  // Output holding register: valid clears on i_ready unless a new frame loads
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_valid      <= 1'b0;
      o_data       <= '0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_overrun <= overrun_c;
      if (load_c) begin
        o_valid     <= 1'b1;
        o_data      <= shreg;
        o_frame_err <= ferr_acc;
`ifdef UART_RX_PARITY_EN
        o_parity_err <= ((^shreg) ^ parity_bit) != PAR_MODE;
`else
        o_parity_err <= 1'b0;
`endif
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: a default instance (1 stop bit) and a
// STOP_BITS=2 instance; parity cases follow UART_RX_PARITY_EN.
module tb_uart_rx_core;

  localparam int unsigned NB = 8;
  localparam int unsigned NT = 16;

  typedef struct packed {
    logic [NB-1:0] data;
    logic          ferr;
    logic          perr;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          tick = 1'b0;
  logic [1:0]    div = 2'd0;
  logic          rx = 1'b1;
  logic          rx2 = 1'b1;
  logic          ready = 1'b1;
  logic          ready2 = 1'b1;
  logic          valid, ferr, perr, ovr;
  logic          valid2, ferr2, perr2, ovr2;
  logic [NB-1:0] data, data2;

  exp_t q1[$];
  exp_t q2[$];
  int   checks = 0;
  int   errors = 0;
  int   ovr_count = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    div  <= div + 2'd1;
    tick <= (div == 2'd3);
  end

  uart_rx_core #(.NB_DATA(NB), .N_TICKS(NT), .STOP_BITS(1), .PARITY_ODD(0)) u_dut (
    .i_clock(clk), .i_reset(reset), .i_rx(rx), .i_signal_tick(tick), .i_ready(ready),
    .o_valid(valid), .o_data(data), .o_frame_err(ferr), .o_parity_err(perr), .o_overrun(ovr)
  );

  uart_rx_core #(.NB_DATA(NB), .N_TICKS(NT), .STOP_BITS(2), .PARITY_ODD(0)) u_dut2 (
    .i_clock(clk), .i_reset(reset), .i_rx(rx2), .i_signal_tick(tick), .i_ready(ready2),
    .o_valid(valid2), .o_data(data2), .o_frame_err(ferr2), .o_parity_err(perr2), .o_overrun(ovr2)
  );

  // Scoreboard: each accepted frame is popped and compared against its expectation
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (valid && ready) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL dut1_unexpected_frame: got data=%h ferr=%b perr=%b, required none", data, ferr, perr);
        end else begin
          e = q1.pop_front();
          if ({data, ferr, perr} !== {e.data, e.ferr, e.perr}) begin
            errors++;
            $display("FAIL dut1_frame: got data=%h ferr=%b perr=%b, required data=%h ferr=%b perr=%b",
                     data, ferr, perr, e.data, e.ferr, e.perr);
          end
        end
      end
      if (valid2 && ready2) begin
        checks++;
        if (q2.size() == 0) begin
          errors++;
          $display("FAIL dut2_unexpected_frame: got data=%h ferr=%b perr=%b, required none", data2, ferr2, perr2);
        end else begin
          e = q2.pop_front();
          if ({data2, ferr2, perr2} !== {e.data, e.ferr, e.perr}) begin
            errors++;
            $display("FAIL dut2_frame: got data=%h ferr=%b perr=%b, required data=%h ferr=%b perr=%b",
                     data2, ferr2, perr2, e.data, e.ferr, e.perr);
          end
        end
      end
      if (ovr) ovr_count++;
      if (ovr2) begin
        checks++;
        errors++;
        $display("FAIL dut2_overrun: got overrun=1, required 0");
      end
    end
  end

  function automatic logic exp_perr(input logic [NB-1:0] d, input logic p);
`ifdef UART_RX_PARITY_EN
    return (^d) ^ p;
`else
    return 1'b0 & (^d) & p;
`endif
  endfunction

  function automatic exp_t mk(input logic [NB-1:0] d, input logic fe, input logic pb);
    exp_t e;
    e.data = d;
    e.ferr = fe;
    e.perr = exp_perr(d, pb);
    return e;
  endfunction

  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(negedge clk);
      if (tick) k++;
    end
  endtask

  task automatic drive_line(input logic sel, input logic v);
    if (sel) rx2 = v;
    else     rx  = v;
  endtask

  task automatic send_frame(input logic sel, input logic [NB-1:0] d, input logic pbit,
                            input logic stop_lo1, input logic stop_lo2);
    logic lo;
    drive_line(sel, 1'b0);
    wait_ticks(NT);
    for (int i = 0; i < NB; i++) begin
      drive_line(sel, d[i]);
      wait_ticks(NT);
    end
`ifdef UART_RX_PARITY_EN
    drive_line(sel, pbit);
    wait_ticks(NT);
`endif
    for (int s = 0; s < (sel ? 2 : 1); s++) begin
      lo = (s == 0) ? stop_lo1 : stop_lo2;
      if (lo) begin
        drive_line(sel, 1'b0);
        wait_ticks(10);
        drive_line(sel, 1'b1);
        wait_ticks(NT - 10);
      end else begin
        drive_line(sel, 1'b1);
        wait_ticks(NT);
      end
    end
    drive_line(sel, 1'b1);
    wait_ticks(2 * NT);
  endtask

  task automatic drain;
    int n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got pending q1=%0d q2=%0d, required 0", q1.size(), q2.size());
    end
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 ready = v;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (valid !== 1'b0 || valid2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b/%b, required 0/0", valid, valid2);
    end
    checks++;
    if (data !== 8'h00 || data2 !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: got %h/%h, required 00/00", data, data2);
    end
    checks++;
    if ({ferr, perr, ovr} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 000", {ferr, perr, ovr});
    end
    @(posedge clk);
    #1 reset = 1'b0;
    wait_ticks(4);
  endtask

  task automatic test_basic;
    logic [NB-1:0] pats [4];
    pats[0] = 8'hA5; pats[1] = 8'h00; pats[2] = 8'hFF; pats[3] = 8'h3A;
    for (int i = 0; i < 4; i++) begin
      q1.push_back(mk(pats[i], 1'b0, ^pats[i]));
      send_frame(1'b0, pats[i], ^pats[i], 1'b0, 1'b0);
    end
    q2.push_back(mk(8'hC3, 1'b0, ^8'hC3));
    send_frame(1'b1, 8'hC3, ^8'hC3, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_glitch;
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(3 * NT);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL glitch_valid: got %b, required 0", valid);
    end
    q1.push_back(mk(8'h81, 1'b0, ^8'h81));
    send_frame(1'b0, 8'h81, ^8'h81, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_frame_err;
    q1.push_back(mk(8'h3C, 1'b1, ^8'h3C));
    send_frame(1'b0, 8'h3C, ^8'h3C, 1'b1, 1'b0);
    q2.push_back(mk(8'h3C, 1'b1, ^8'h3C));
    send_frame(1'b1, 8'h3C, ^8'h3C, 1'b0, 1'b1);
    q2.push_back(mk(8'h96, 1'b1, ^8'h96));
    send_frame(1'b1, 8'h96, ^8'h96, 1'b1, 1'b0);
    drain();
  endtask

  task automatic test_parity;
    q1.push_back(mk(8'h01, 1'b0, 1'b0));
    send_frame(1'b0, 8'h01, 1'b0, 1'b0, 1'b0);
    q1.push_back(mk(8'h01, 1'b0, 1'b1));
    send_frame(1'b0, 8'h01, 1'b1, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_overrun;
    int ovr0;
    ovr0 = ovr_count;
    set_ready(1'b0);
    q1.push_back(mk(8'h11, 1'b0, ^8'h11));
    send_frame(1'b0, 8'h11, ^8'h11, 1'b0, 1'b0);
    send_frame(1'b0, 8'h22, ^8'h22, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (valid !== 1'b1 || data !== 8'h11) begin
      errors++;
      $display("FAIL overrun_hold: got valid=%b data=%h, required valid=1 data=11", valid, data);
    end
    checks++;
    if (ovr_count - ovr0 != 1) begin
      errors++;
      $display("FAIL overrun_pulses: got %0d, required 1", ovr_count - ovr0);
    end
    set_ready(1'b1);
    repeat (3) @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: got valid=%b, required 0", valid);
    end
    drain();
  endtask

  task automatic test_reset_mid;
    logic [NB-1:0] d;
    d = 8'h55;
    rx = 1'b0;
    wait_ticks(NT);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      wait_ticks(NT);
    end
    rx = d[4];
    wait_ticks(4);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_valid: got %b, required 0", valid);
    end
    rx = 1'b1;
    wait_ticks(2 * NT);
    q1.push_back(mk(8'h66, 1'b0, ^8'h66));
    send_frame(1'b0, 8'h66, ^8'h66, 1'b0, 1'b0);
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_parity();
    test_overrun();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 Parameter NB_DATA, default 8: data bits per frame, legal range 5..9.
REQ-002 Parameter N_TICKS, default 16: oversampling ticks per bit, even, minimum 8.
REQ-003 Parameter STOP_BITS, default 1: stop bits per frame, 1 or 2.
REQ-004 Parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd; used only with UART_RX_PARITY_EN.
REQ-005 i_clock  in  1  system clock.
REQ-006 i_reset  in  1  synchronous, active-high reset.
REQ-007 i_rx  in  1  asynchronous serial line; idles high.
REQ-008 i_signal_tick  in  1  one-cycle pulse at N_TICKS times the baud rate.
REQ-009 i_ready  in  1  consumer accepts the held frame.
REQ-010 o_valid  out  1  frame held in the output register.
REQ-011 o_data  out  NB_DATA  received data, LSB first on the line, bit 0 = first data bit.
REQ-012 o_frame_err  out  1  a stop bit of the held frame sampled low.
REQ-013 o_parity_err  out  1  parity mismatch on the held frame; tied 0 without the macro.
REQ-014 o_overrun  out  1  one-cycle pulse when a completed frame is dropped.

Function
REQ-015 i_rx SHALL pass a 2-flop synchronizer; all FSM decisions use the synchronized value.
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, DONE, one-hot.
REQ-017 IDLE -> START when synchronized rx = 0; tick counter cleared.
REQ-018 In START, on tick with counter = N_TICKS/2-1: rx = 1 -> IDLE (glitch reject, no output); rx = 0 -> DATA, counter and bit index cleared.
REQ-019 In DATA/PARITY/STOP the counter SHALL run 0..N_TICKS-1 per bit, advancing only on i_signal_tick.
REQ-020 Each bit value SHALL be the 2-of-3 majority of rx at counts N_TICKS-3, N_TICKS-2, N_TICKS-1, decided on the tick at N_TICKS-1.
REQ-021 DATA SHALL shift NB_DATA majority bits in LSB first, then go to PARITY (macro defined) or STOP.
REQ-022 STOP SHALL sample STOP_BITS bits; frame error = any stop bit low; after the last one -> DONE.
REQ-023 DONE lasts one cycle: if o_valid = 0, or o_valid = 1 with i_ready = 1 that same cycle, load o_data and the error flags and set o_valid; otherwise keep the held frame and pulse o_overrun. Then -> IDLE.
REQ-024 o_valid SHALL clear the cycle after i_ready = 1 when no new load happens; o_valid depends only on i_ready, not on FSM state.
REQ-025 The output register SHALL be loaded the cycle after the final stop-bit decision tick.
REQ-026 A frame error SHALL NOT suppress delivery; data is delivered with o_frame_err = 1.
REQ-027 Undefined state encodings SHALL return to IDLE with counters cleared.

Reset
REQ-028 On reset: FSM = IDLE, counters and shift register 0, o_valid = 0, o_data = 0, o_frame_err = 0, o_parity_err = 0, o_overrun = 0, synchronizer flops = 1.
REQ-029 Reset mid-frame SHALL abandon the frame with no output; reception restarts at the next falling edge after reset releases.

Configuration
REQ-030 With UART_RX_PARITY_EN defined: PARITY state samples one bit; o_parity_err = XOR(data, parity bit) != PARITY_ODD.
REQ-031 Without UART_RX_PARITY_EN: no PARITY state and no parity logic; o_parity_err is constant 0.

Structure
REQ-032 Package uart_pkg SHALL hold the state encodings, the NB_STATE width and the parity-mode constants.
REQ-033 Sub-module uart_rx_sync SHALL implement the 2-flop synchronizer with reset value 1.

Verification (NB_DATA=8, N_TICKS=16, STOP_BITS=1 unless noted)
REQ-034 Frame 0xA5 with i_ready held 1 -> o_valid pulses, o_data = 0xA5, both error flags 0.
REQ-035 Low pulse of 4 ticks on an idle line -> FSM returns to IDLE, o_valid stays 0.
REQ-036 0x3C with stop bit low -> o_data = 0x3C, o_frame_err = 1; STOP_BITS=2 with second stop low -> o_frame_err = 1.
REQ-037 Macro defined, PARITY_ODD=0, 0x01 with parity bit 0 -> o_parity_err = 1; with parity bit 1 -> o_parity_err = 0.
REQ-038 0x11 then 0x22 with i_ready = 0 -> o_data stays 0x11, one o_overrun pulse; raising i_ready clears o_valid.
REQ-039 Reset asserted at data bit 4 of 0x55, then 0x66 sent -> only 0x66 delivered.
